// File: rtl/fpu_ctrl_pkg.sv
// Shared decode constants and FSM state type for the FPU issue controller.
package fpu_ctrl_pkg;

    localparam logic [6:0] OPC_OPFP = 7'b1010011;
    localparam logic [6:0] OPC_FSW  = 7'b0100111;

    localparam logic [6:0] F7_FADD = 7'b0000000;
    localparam logic [6:0] F7_FSUB = 7'b0000100;
    localparam logic [6:0] F7_FMUL = 7'b0001000;

    localparam logic [31:0] FPU_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fpu_issue_state_t;

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register in-flight write counters for the FPU register file (no bypass).
// LAT (2..7) is the issue-to-dependent-issue distance in cycles.
module fpu_scoreboard #(
    parameter int LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic [4:0] rd_a,
    input  logic [4:0] rd_b,
    output logic [1:0] src_busy,
    output logic       busy_o,
    output logic       empty_next
);

    localparam logic [2:0] LOAD_VAL = 3'(LAT - 1);

    logic [2:0] cnt_q [32];
    logic [2:0] cnt_d [32];

    // A set and a decrement on the same register resolve to the set (WAW reload).
    always_comb begin
        busy_o     = 1'b0;
        empty_next = 1'b1;
        for (int f = 0; f < 32; f++) begin
            cnt_d[f] = (cnt_q[f] != 3'd0) ? cnt_q[f] - 3'd1 : 3'd0;
            if (set_en && set_idx == 5'(f)) begin
                cnt_d[f] = LOAD_VAL;
            end
            if (cnt_q[f] != 3'd0) begin
                busy_o = 1'b1;
            end
            if (cnt_d[f] != 3'd0) begin
                empty_next = 1'b0;
            end
        end
    end

    assign src_busy[0] = (cnt_q[rd_a] != 3'd0);
    assign src_busy[1] = (cnt_q[rd_b] != 3'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < 32; f++) begin
                cnt_q[f] <= 3'd0;
            end
        end else begin
            for (int f = 0; f < 32; f++) begin
                cnt_q[f] <= cnt_d[f];
            end
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller between decode and the PRE/EX/NORMAL FPU pipeline.
// Optional FPU_ISSUE_STATS_EN adds stall-cycle and issued-op counters.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst_i,
    output logic        inst_ready,
    output logic [31:0] fpu_inst_o,
    output logic        stall_o,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        busy_o
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_issue
`endif
);

    // state | meaning
    // RUN   | accepting; drain_req starts a drain
    // STALL | FP instruction waiting on an in-flight source write
    // DRAIN | no accepts; waiting for the scoreboard to empty
    // DONE  | one-cycle drain_done pulse, then back to RUN

    fpu_issue_state_t state_q, state_d;

    logic       is_arith, is_fsw, is_fp, hazard, accept;
    logic [1:0] src_busy;
    logic       empty_next;

    assign is_arith = (inst_i[6:0] == OPC_OPFP) &&
                      (inst_i[31:25] == F7_FADD || inst_i[31:25] == F7_FSUB ||
                       inst_i[31:25] == F7_FMUL);
    assign is_fsw   = (inst_i[6:0] == OPC_FSW);
    assign is_fp    = is_arith || is_fsw;
    assign hazard   = (is_arith && src_busy[0]) || (is_fp && src_busy[1]);

    fpu_scoreboard #(.LAT(LAT)) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en     (accept && is_arith),
        .set_idx    (inst_i[11:7]),
        .rd_a       (inst_i[19:15]),
        .rd_b       (inst_i[24:20]),
        .src_busy   (src_busy),
        .busy_o     (busy_o),
        .empty_next (empty_next)
    );

    // DRAIN exits on the edge where the last counter reaches zero, so DONE
    // is the first cycle with an empty scoreboard.
    always_comb begin
        state_d    = state_q;
        inst_ready = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            RUN: begin
                inst_ready = !hazard;
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (inst_valid && hazard) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                inst_ready = !hazard;
                if (!hazard) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                drain_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign accept     = inst_valid && inst_ready;
    assign fpu_inst_o = (accept && is_fp) ? inst_i : FPU_NOP;
    assign stall_o    = inst_valid && !inst_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    logic [31:0] stat_stall_q, stat_issue_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stall_q <= 32'd0;
            stat_issue_q <= 32'd0;
        end else begin
            if (stall_o) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            if (accept && is_fp) begin
                stat_issue_q <= stat_issue_q + 32'd1;
            end
        end
    end

    assign stat_stall = stat_stall_q;
    assign stat_issue = stat_issue_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: per-cycle model in terms of
// register ready times plus directed scenarios with literal expectations.
module tb_fpu_issue_ctrl;

    localparam int LAT = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk, rst, inst_valid, drain_req;
    logic [31:0] inst_i;
    logic        inst_ready, stall_o, drain_done, busy_o;
    logic [31:0] fpu_inst_o;
`ifdef FPU_ISSUE_STATS_EN
    logic [31:0] stat_stall, stat_issue;
`endif

    fpu_issue_ctrl #(.LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_i     (inst_i),
        .inst_ready (inst_ready),
        .fpu_inst_o (fpu_inst_o),
        .stall_o    (stall_o),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy_o     (busy_o)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_issue (stat_issue)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: ready_at[f] is the first cycle in which f may be read again.
    int   ready_at [32];
    int   mode;
    int   m_stall, m_issue;
    logic rst_seen;
    logic m_arith, m_fp, m_haz, m_any, m_left, e_ready, e_acc;

    always @(negedge rst) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (!rst || rst_seen) begin
            for (int i = 0; i < 32; i++) ready_at[i] = 0;
            mode     = M_RUN;
            m_stall  = 0;
            m_issue  = 0;
            rst_seen = 1'b0;
        end
        m_arith = (inst_i[6:0] == 7'b1010011) &&
                  (inst_i[31:25] == 7'h00 || inst_i[31:25] == 7'h04 || inst_i[31:25] == 7'h08);
        m_fp    = m_arith || (inst_i[6:0] == 7'b0100111);
        m_haz   = (m_arith && ready_at[inst_i[19:15]] > cyc) ||
                  (m_fp && ready_at[inst_i[24:20]] > cyc);
        m_any   = 1'b0;
        for (int i = 0; i < 32; i++) if (ready_at[i] > cyc) m_any = 1'b1;
        e_ready = (mode == M_RUN || mode == M_STALL) && !m_haz;
        e_acc   = inst_valid && e_ready;

        chk("inst_ready", {31'd0, inst_ready}, {31'd0, e_ready});
        chk("fpu_inst_o", fpu_inst_o, (e_acc && m_fp) ? inst_i : NOP);
        chk("stall_o", {31'd0, stall_o}, {31'd0, inst_valid && !e_ready});
        chk("busy_o", {31'd0, busy_o}, {31'd0, m_any});
        chk("drain_done", {31'd0, drain_done}, {31'd0, mode == M_DONE});
`ifdef FPU_ISSUE_STATS_EN
        chk("stat_stall", stat_stall, m_stall);
        chk("stat_issue", stat_issue, m_issue);
`endif
        if (rst) begin
            if (e_acc && m_arith) ready_at[inst_i[11:7]] = cyc + LAT;
            if (inst_valid && !e_ready) m_stall++;
            if (e_acc && m_fp) m_issue++;
            case (mode)
                M_RUN:   if (drain_req) mode = M_DRAIN;
                         else if (inst_valid && m_haz) mode = M_STALL;
                M_STALL: if (!m_haz) mode = M_RUN;
                M_DRAIN: begin
                    m_left = 1'b0;
                    for (int i = 0; i < 32; i++) if (ready_at[i] > cyc + 1) m_left = 1'b1;
                    if (!m_left) mode = M_DONE;
                end
                default: mode = M_RUN;
            endcase
        end
        cyc++;
    end

    function automatic logic [31:0] op_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b1010011};
    endfunction

    function automatic logic [31:0] op_fsw(input int rs2);
        return {7'd0, 5'(rs2), 5'd1, 3'b010, 5'd0, 7'b0100111};
    endfunction

    // Present w until accepted; stalls = cycles with stall_o high before accept.
    task automatic send(input logic [31:0] w, output int stalls, output logic [31:0] fo);
        int n;
        inst_valid = 1'b1;
        inst_i     = w;
        stalls     = 0;
        n          = 0;
        fo         = 32'hx;
        @(negedge clk);
        while (!inst_ready && n < 50) begin
            if (stall_o) stalls++;
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        fo = fpu_inst_o;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst_i     = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Counts negedges until drain_done, checking inst_ready stays low.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            chk("drain_inst_ready", {31'd0, inst_ready}, 32'd0);
        end while (!drain_done && n < 20);
    endtask

    int          s;
    int          n;
    logic [31:0] fo, w;

    initial begin
        rst        = 1'b0;
        inst_valid = 1'b0;
        inst_i     = 32'h0;
        drain_req  = 1'b0;
        rst_seen   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("rst_fpu_inst", fpu_inst_o, 32'h0000_0013);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_drain_done", {31'd0, drain_done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // RAW: fadd f3,f1,f2 then fmul f4,f3,f3
        send(op_r(7'h00, 3, 1, 2), s, fo);
        chk("s1_fadd_stalls", s, 0);
        w = op_r(7'h08, 4, 3, 3);
        send(w, s, fo);
        chk("s1_fmul_stalls", s, 2);
        chk("s1_fmul_issue", fo, w);
`ifdef FPU_ISSUE_STATS_EN
        chk("s1_stat_stall", stat_stall, 32'd2);
        chk("s1_stat_issue", stat_issue, 32'd2);
`endif
        idle(4);

        // fadd f5 then fsw f5; then fsw f6 with f6 idle
        send(op_r(7'h00, 5, 1, 2), s, fo);
        send(op_fsw(5), s, fo);
        chk("s2_fsw_stalls", s, 2);
        idle(4);
        send(op_fsw(6), s, fo);
        chk("s2_fsw_idle_stalls", s, 0);
        idle(2);

        // non-FP while f1 busy
        send(op_r(7'h04, 1, 2, 2), s, fo);
        send(32'h00A0_0093, s, fo);
        chk("s3_nonfp_stalls", s, 0);
        chk("s3_nonfp_nop", fo, 32'h0000_0013);
        idle(4);

        // WAW on f7, then reader of f7
        send(op_r(7'h00, 7, 1, 2), s, fo);
        send(op_r(7'h00, 7, 1, 2), s, fo);
        chk("s4_waw_stalls", s, 0);
        send(op_r(7'h00, 11, 7, 7), s, fo);
        chk("s4_reader_stalls", s, 2);
        idle(4);

        // drain with a writer accepted in the same cycle
        drain_req = 1'b1;
        send(op_r(7'h00, 8, 1, 2), s, fo);
        drain_req = 1'b0;
        chk("s5_fadd_stalls", s, 0);
        wait_done(n);
        chk("s5_drain_latency", n, 3);
        idle(2);

        // drain with an empty scoreboard
        drain_req = 1'b1;
        @(posedge clk);
        #1 drain_req = 1'b0;
        wait_done(n);
        chk("s5_empty_drain_latency", n, 2);
        idle(2);

        // reset during STALL
        send(op_r(7'h00, 9, 1, 2), s, fo);
        inst_valid = 1'b1;
        inst_i     = op_r(7'h08, 10, 9, 9);
        @(negedge clk);
        chk("s6_stall_before_rst", {31'd0, stall_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("s6_rst_inst_ready", {31'd0, inst_ready}, 32'd1);
        chk("s6_rst_busy", {31'd0, busy_o}, 32'd0);
`ifdef FPU_ISSUE_STATS_EN
        chk("s6_rst_stat_stall", stat_stall, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("s6_issue_after_rst", {31'd0, inst_ready}, 32'd1);
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst_i     = 32'h0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
